// File: rtl/sram_wrapper_pkg.sv
// rtl/sram_wrapper_pkg.sv - shared AXI widths, wrapper state enum and response codes
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package sram_wrapper_pkg;

    localparam int AXI_DATA_BITS  = 32;
    localparam int SRAM_ADDR_BITS = 14;

    typedef enum logic [2:0] {
        IDLE,
        R_FETCH,
        R_DATA,
        W_DATA,
        W_RESP
    } sram_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sram_wrapper.sv
// rtl/sram_wrapper.sv - AXI slave front end for a single-port 16K x 32 SRAM macro
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module sram_wrapper
    import sram_wrapper_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [31:0]               ARADDR_S,
    input  logic [3:0]                ARLEN_S,
    input  logic [2:0]                ARSIZE_S,
    input  logic [1:0]                ARBURST_S,
    input  logic                      ARVALID_S,
    output logic                      ARREADY_S,
    output logic [`AXI_IDS_BITS-1:0]  RID_S,
    output logic [31:0]               RDATA_S,
    output logic [1:0]                RRESP_S,
    output logic                      RLAST_S,
    output logic                      RVALID_S,
    input  logic                      RREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]  AWID_S,
    input  logic [31:0]               AWADDR_S,
    input  logic [3:0]                AWLEN_S,
    input  logic [2:0]                AWSIZE_S,
    input  logic [1:0]                AWBURST_S,
    input  logic                      AWVALID_S,
    output logic                      AWREADY_S,
    input  logic [31:0]               WDATA_S,
    input  logic [3:0]                WSTRB_S,
    input  logic                      WLAST_S,
    input  logic                      WVALID_S,
    output logic                      WREADY_S,
    output logic [`AXI_IDS_BITS-1:0]  BID_S,
    output logic [1:0]                BRESP_S,
    output logic                      BVALID_S,
    input  logic                      BREADY_S,
    output logic                      CEB,
    output logic                      OEB,
    output logic [3:0]                WEB,
    output logic [13:0]               A,
    output logic [31:0]               DI,
    input  logic [31:0]               DO
);

    sram_state_e                     state_q, state_d;
    logic [`AXI_IDS_BITS-1:0]        id_q, id_d;
    logic [SRAM_ADDR_BITS-1:0]       addr_q, addr_d;
    logic [3:0]                      len_q, len_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic [AXI_DATA_BITS-1:0]        rdata_q, rdata_d;
    logic                            rvalid_q, rvalid_d;
    logic [1:0]                      bresp_q, bresp_d;

    // Size, burst type and upper address bits carry no meaning for this memory.
    logic unused_inputs;
    assign unused_inputs = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S,
                             ARADDR_S[31:16], ARADDR_S[1:0],
                             AWADDR_S[31:16], AWADDR_S[1:0]};

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        bresp_d  = bresp_q;
        case (state_q)
            IDLE: begin
                if (AWVALID_S) begin
                    id_d    = AWID_S;
                    addr_d  = AWADDR_S[15:2];
                    len_d   = AWLEN_S;
                    cnt_d   = 4'd0;
                    state_d = W_DATA;
                end else if (ARVALID_S) begin
                    id_d    = ARID_S;
                    addr_d  = ARADDR_S[15:2];
                    len_d   = ARLEN_S;
                    cnt_d   = 4'd0;
                    state_d = R_FETCH;
                end
            end
            R_FETCH: state_d = R_DATA;
            R_DATA: begin
                // First cycle waits for the macro output, then the beat is held until accepted.
                if (!rvalid_q) begin
                    rdata_d  = DO;
                    rvalid_d = 1'b1;
                end else if (RREADY_S) begin
                    rvalid_d = 1'b0;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 14'd1;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = R_FETCH;
                    end
                end
            end
            W_DATA: begin
                if (WVALID_S) begin
                    addr_d = addr_q + 14'd1;
                    cnt_d  = cnt_q + 4'd1;
                    if (WLAST_S) begin
                        bresp_d = (cnt_q == len_q) ? RESP_OKAY : RESP_SLVERR;
                        state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY_S) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    assign AWREADY_S = (state_q == IDLE);
    assign ARREADY_S = (state_q == IDLE) && !AWVALID_S;
    assign WREADY_S  = (state_q == W_DATA);
    assign BVALID_S  = (state_q == W_RESP);
    assign BID_S     = id_q;
    assign BRESP_S   = bresp_q;
    assign RVALID_S  = rvalid_q;
    assign RDATA_S   = rdata_q;
    assign RID_S     = id_q;
    assign RRESP_S   = RESP_OKAY;
    assign RLAST_S   = rvalid_q && (cnt_q == len_q);

    // Macro strobes are combinational so a write beat lands in its handshake cycle.
    always_comb begin
        CEB = 1'b1;
        OEB = 1'b1;
        WEB = 4'hF;
        A   = addr_q;
        DI  = '0;
        if (state_q == R_FETCH) begin
            CEB = 1'b0;
            OEB = 1'b0;
        end else if ((state_q == W_DATA) && WVALID_S) begin
            CEB = 1'b0;
            WEB = ~WSTRB_S;
            DI  = WDATA_S;
        end
    end

endmodule

// File: tb/tb_sram_wrapper.sv
// tb/tb_sram_wrapper.sv - randomized self-checking bench for sram_wrapper with an SRAM model
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module tb_sram_wrapper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [`AXI_IDS_BITS-1:0] ARID_S, RID_S, AWID_S, BID_S;
    logic [31:0] ARADDR_S, AWADDR_S, RDATA_S, WDATA_S, DI;
    logic [31:0] DO = '0;
    logic [3:0]  ARLEN_S, AWLEN_S, WSTRB_S, WEB;
    logic [2:0]  ARSIZE_S, AWSIZE_S;
    logic [1:0]  ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
    logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
    logic        AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
    logic        BVALID_S, BREADY_S, CEB, OEB;
    logic [13:0] A;

    sram_wrapper dut (
        .clk(clk), .rst(rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
        .BREADY_S(BREADY_S),
        .CEB(CEB), .OEB(OEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    // Behavioural macro: registered read data, per-byte active-low write enables.
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (!CEB) begin
            if (!OEB) DO <= mem[A];
            for (int b = 0; b < 4; b++)
                if (!WEB[b]) mem[A][8*b +: 8] = DI[8*b +: 8];
            if (WEB != 4'hF) wr_cnt <= wr_cnt + 1;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [13:0] wbase, rbase;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int t;
        AWADDR_S = addr; AWLEN_S = len; AWID_S = id; AWSIZE_S = 3'd2; AWBURST_S = 2'd1;
        AWVALID_S = 1'b1;
        wbase = addr[15:2];
        #1; t = 0;
        while (!AWREADY_S && t < 100) begin @(negedge clk); #1; t++; end
        chk("aw_ready", AWREADY_S, 1);
        @(posedge clk);
        @(negedge clk);
        AWVALID_S = 1'b0;
    endtask

    task automatic w_phase(input int nbeats);
        int t;
        logic [13:0] a;
        for (int i = 0; i < nbeats; i++) begin
            WDATA_S = wdat[i]; WSTRB_S = wstb[i]; WLAST_S = (i == nbeats - 1); WVALID_S = 1'b1;
            #1; t = 0;
            while (!WREADY_S && t < 100) begin @(negedge clk); #1; t++; end
            chk("w_ready", WREADY_S, 1);
            @(posedge clk);
            a = wbase + 14'(i);
            for (int b = 0; b < 4; b++)
                if (wstb[i][b]) ref_mem[a][8*b +: 8] = wdat[i][8*b +: 8];
            @(negedge clk);
        end
        WVALID_S = 1'b0; WLAST_S = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] exp_resp, input logic [7:0] exp_id);
        int t;
        BREADY_S = 1'b1;
        #1; t = 0;
        while (!BVALID_S && t < 100) begin @(negedge clk); #1; t++; end
        chk("b_valid", BVALID_S, 1);
        chk("b_resp", BRESP_S, exp_resp);
        chk("b_id", BID_S, exp_id);
        @(posedge clk);
        @(negedge clk);
        BREADY_S = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int t;
        ARADDR_S = addr; ARLEN_S = len; ARID_S = id; ARSIZE_S = 3'd2; ARBURST_S = 2'd1;
        ARVALID_S = 1'b1;
        rbase = addr[15:2];
        #1; t = 0;
        while (!ARREADY_S && t < 100) begin @(negedge clk); #1; t++; end
        chk("ar_ready", ARREADY_S, 1);
        @(posedge clk);
        #1;
        ARVALID_S = 1'b0;
    endtask

    task automatic r_phase(input int len, input logic [7:0] id, input int stall_beat,
                           input int stall_cyc, input string tag);
        int t;
        logic [31:0] exp;
        @(negedge clk); #1; t = 0;
        while (!RVALID_S && t < 50) begin @(negedge clk); #1; t++; end
        chk({tag, "_latency"}, t, 2);
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!RVALID_S && t < 50) begin @(negedge clk); #1; t++; end
            exp = ref_mem[rbase + 14'(i)];
            chk({tag, "_rvalid"}, RVALID_S, 1);
            chk({tag, "_rdata"}, RDATA_S, exp);
            chk({tag, "_rlast"}, RLAST_S, (i == len));
            chk({tag, "_rid"}, RID_S, id);
            chk({tag, "_rresp"}, RRESP_S, 2'b00);
            if (i == stall_beat) begin
                repeat (stall_cyc) begin @(negedge clk); #1; end
                chk({tag, "_stall_valid"}, RVALID_S, 1);
                chk({tag, "_stall_data"}, RDATA_S, exp);
                chk({tag, "_stall_last"}, RLAST_S, (i == len));
            end
            RREADY_S = 1'b1;
            @(posedge clk);
            @(negedge clk);
            RREADY_S = 1'b0;
            #1;
        end
        chk({tag, "_rvalid_done"}, RVALID_S, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ceb"}, CEB, 1);
        chk({tag, "_oeb"}, OEB, 1);
        chk({tag, "_web"}, WEB, 4'hF);
        chk({tag, "_rvalid"}, RVALID_S, 0);
        chk({tag, "_bvalid"}, BVALID_S, 0);
        chk({tag, "_wready"}, WREADY_S, 0);
        chk({tag, "_arready"}, ARREADY_S, 1);
        chk({tag, "_awready"}, AWREADY_S, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  len;
        int nb, wc;
        rst = 1'b0;
        {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S} = '0;
        {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S} = '0;
        {WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S} = '0;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = $urandom();
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single read of a preloaded word.
        mem[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
        ar_phase(32'h40, 4'd0, 8'h03);
        r_phase(0, 8'h03, -1, 0, "single");

        // Four-beat read with a stall on beat 1.
        ar_phase(32'h100, 4'd3, 8'h05);
        r_phase(3, 8'h05, 1, 3, "burst");

        // Partial byte write then read back.
        mem[14'h200] = 32'hAABBCCDD; ref_mem[14'h200] = 32'hAABBCCDD;
        wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
        aw_phase(32'h800, 4'd0, 8'h07);
        w_phase(1);
        b_phase(2'b00, 8'h07);
        chk("byte_word", mem[14'h200], 32'hAA22CC44);
        ar_phase(32'h800, 4'd0, 8'h07);
        r_phase(0, 8'h07, -1, 0, "byte_rd");

        // Simultaneous AW and AR: write wins, read sees the new data.
        ARADDR_S = 32'hC00; ARLEN_S = 4'd0; ARID_S = 8'h0A; ARVALID_S = 1'b1;
        AWADDR_S = 32'hC00; AWLEN_S = 4'd0; AWID_S = 8'h09; AWVALID_S = 1'b1;
        #1;
        chk("both_arready", ARREADY_S, 0);
        chk("both_awready", AWREADY_S, 1);
        wdat[0] = $urandom(); wstb[0] = 4'hF;
        aw_phase(32'hC00, 4'd0, 8'h09);
        w_phase(1);
        b_phase(2'b00, 8'h09);
        chk("both_mem", mem[14'h300], wdat[0]);
        ar_phase(32'hC00, 4'd0, 8'h0A);
        r_phase(0, 8'h0A, -1, 0, "both_rd");

        // Early WLAST at the top word, then a read across the wrap.
        wdat[0] = $urandom(); wstb[0] = 4'hF;
        aw_phase(32'hFFFC, 4'd1, 8'h02);
        w_phase(1);
        b_phase(2'b10, 8'h02);
        chk("wrap_top", mem[14'h3FFF], wdat[0]);
        chk("wrap_zero_untouched", mem[14'h0000], ref_mem[14'h0000]);
        ar_phase(32'hFFFC, 4'd1, 8'h04);
        r_phase(1, 8'h04, -1, 0, "wrap_rd");

        // Randomized traffic against the reference memory.
        for (int it = 0; it < 24; it++) begin
            addr = $urandom();
            addr[1:0] = 2'b00;
            len = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(len) + 1) : int'(len) + 1;
                for (int i = 0; i < nb; i++) begin
                    wdat[i] = $urandom();
                    wstb[i] = 4'($urandom_range(0, 15));
                end
                aw_phase(addr, len, 8'(it));
                w_phase(nb);
                b_phase((nb == int'(len) + 1) ? 2'b00 : 2'b10, 8'(it));
            end else begin
                ar_phase(addr, len, 8'(it));
                r_phase(int'(len), 8'(it), $urandom_range(0, int'(len)), $urandom_range(0, 3), "rand");
            end
        end

        // Reset during beat 1 of a four-beat write.
        aw_phase(32'h1000, 4'd3, 8'h06);
        wdat[0] = $urandom();
        WDATA_S = wdat[0]; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b1;
        #1;
        chk("rst_beat0_wready", WREADY_S, 1);
        @(posedge clk);
        ref_mem[wbase] = wdat[0];
        @(negedge clk);
        WDATA_S = $urandom();
        rst = 1'b0;
        #1;
        wc = wr_cnt;
        chk_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        WVALID_S = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_write", wr_cnt, wc);
        chk("midrst_beat0", mem[wbase], ref_mem[wbase]);
        chk("midrst_beat1", mem[wbase + 14'd1], ref_mem[wbase + 14'd1]);
        chk_idle_outputs("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_wrapper.md
SRAM_WRAPPER -- requirements
Module: sram_wrapper

Interface
REQ-001 SHALL have one clock and one asynchronous active-low reset: clk input 1, rising-edge clock; rst input 1, active-low, asynchronous assert, synchronous deassert.
REQ-002 SHALL have AXI slave read address ports: ARID_S in `AXI_IDS_BITS; ARADDR_S in 32; ARLEN_S in 4; ARSIZE_S in 3; ARBURST_S in 2; ARVALID_S in 1; ARREADY_S out 1.
REQ-003 SHALL have AXI slave read data ports: RID_S out `AXI_IDS_BITS; RDATA_S out 32; RRESP_S out 2; RLAST_S out 1; RVALID_S out 1; RREADY_S in 1.
REQ-004 SHALL have AXI slave write address ports: AWID_S in `AXI_IDS_BITS; AWADDR_S in 32; AWLEN_S in 4; AWSIZE_S in 3; AWBURST_S in 2; AWVALID_S in 1; AWREADY_S out 1.
REQ-005 SHALL have AXI slave write data and response ports: WDATA_S in 32; WSTRB_S in 4; WLAST_S in 1; WVALID_S in 1; WREADY_S out 1; BID_S out `AXI_IDS_BITS; BRESP_S out 2; BVALID_S out 1; BREADY_S in 1.
REQ-006 SHALL drive the SRAM macro port: CEB out 1, chip enable, active-low; OEB out 1, output enable, active-low; WEB out 4, per-byte write enable, active-low; A out 14, word address; DI out 32, write data; DO in 32, read data, valid one cycle after a read access.

Function
REQ-007 SHALL implement states IDLE, R_FETCH, R_DATA, W_DATA and W_RESP.
REQ-008 In IDLE, SHALL assert AWREADY_S and ARREADY_S combinationally; when AWVALID_S and ARVALID_S are both high, SHALL accept only the write, with ARREADY_S low that cycle.
REQ-009 On an AR handshake, SHALL latch ID, ARADDR_S[15:2] and ARLEN_S, clear the beat counter, and go to R_FETCH.
REQ-010 In R_FETCH, SHALL drive CEB=0, OEB=0, WEB=4'hF and A=current word address, then go to R_DATA; DO SHALL be registered at the end of the following cycle.
REQ-011 In R_DATA, SHALL drive RVALID_S=1, RDATA_S=registered DO, RID_S=latched ID and RRESP_S=2'b00, with RLAST_S=1 when beat count equals latched length; outputs SHALL hold stable until RREADY_S.
REQ-012 On an R handshake, SHALL go to IDLE if RLAST_S is high; otherwise it SHALL increment the address by 1 word and the count by 1, then go to R_FETCH.
REQ-013 Read latency: AR handshake at edge T gives RVALID_S high in cycle T+2; each subsequent beat follows at 2 cycles minimum.
REQ-014 On an AW handshake, SHALL latch ID, AWADDR_S[15:2] and AWLEN_S, clear the count, and go to W_DATA.
REQ-015 In W_DATA, SHALL drive WREADY_S=1; on WVALID_S it SHALL write in the same cycle with CEB=0, OEB=1, WEB=~WSTRB_S, DI=WDATA_S and A=current address, then increment the address and count.
REQ-016 In W_DATA, WLAST_S SHALL end the burst and go to W_RESP; BRESP SHALL be 2'b00 if WLAST_S arrives on beat count equal to the latched length, else 2'b10 (SLVERR).
REQ-017 In W_RESP, SHALL drive BVALID_S=1 with BID_S=latched ID until BREADY_S, then go to IDLE.
REQ-018 Word address SHALL wrap 14'h3FFF -> 14'h0000 within a burst.
REQ-019 ARSIZE/AWSIZE and ARBURST/AWBURST SHALL be ignored; all bursts SHALL be treated as INCR of 4-byte beats.
REQ-020 When no access is in progress, SHALL drive CEB=1, OEB=1 and WEB=4'hF.

Reset
REQ-021 On rst low, SHALL force state=IDLE, counters and latched ID/address/length to 0, RVALID_S, BVALID_S and WREADY_S to 0, CEB=1, OEB=1 and WEB=4'hF; a reset mid-burst SHALL abandon the burst with no further SRAM write.
REQ-022 After reset, ARREADY_S and AWREADY_S SHALL be 1, since the block is in IDLE.

Structure
REQ-023 The state enum and RESP codes (OKAY=2'b00, SLVERR=2'b10) SHALL be placed in the shared AXI package, alongside the `AXI_* width constants.
REQ-024 The block SHALL be a single module; the SRAM macro SHALL be instantiated by the parent and not inside this block.

Verification
REQ-025 Single read: preload word 0x10 = 32'hDEADBEEF; AR at addr 0x40, ARLEN=0 -> RVALID in cycle T+2, RDATA=32'hDEADBEEF, RLAST=1, RRESP=0.
REQ-026 Burst read with backpressure: ARLEN=3 at 0x100 with RREADY low for 3 cycles on beat 1 -> 4 beats in order, RDATA stable while stalled, RLAST only on beat 3.
REQ-027 Byte write: WSTRB=4'b0101, WDATA=32'h11223344 to a word holding 32'hAABBCCDD -> readback 32'hAA22CC44, BRESP=0.
REQ-028 Simultaneous AW and AR in IDLE -> the write completes first, then the read returns the newly written data.
REQ-029 Wrap and error: AWLEN=1 at 0xFFFC with WLAST on beat 0 -> write to word 0x3FFF only, BRESP=2'b10; a separate 2-beat read at 0xFFFC returns word 0x3FFF, then word 0x0000.
REQ-030 Reset mid-burst: assert rst during beat 1 of a 4-beat write -> no SRAM write after the assertion, and all outputs equal the REQ-021/REQ-022 values.
